// File: rtl/scanline_fetch_pkg.sv
// scanline_fetch_pkg: shared geometry, mode codes and fetch state encoding.
package scanline_fetch_pkg;
  localparam logic [7:0] SCREEN_W = 8'd240;
  localparam logic [7:0] SCREEN_H = 8'd160;
  localparam logic [15:0] MODE4_PAGE1_BASE = 16'hA000;
  localparam logic [2:0] MODE3 = 3'h3;
  localparam logic [2:0] MODE4 = 3'h4;
  typedef enum logic [1:0] {IDLE, FETCH3, FETCH4, FINISH} state_t;
endpackage

// File: rtl/line_ram.sv
// line_ram: one 240x15 scanline bank, synchronous write, registered read.
module line_ram (
  input  logic        clk,
  input  logic        i_we,
  input  logic [7:0]  i_waddr,
  input  logic [14:0] i_wdata,
  input  logic [7:0]  i_raddr,
  output logic [14:0] o_rdata
);
  logic [14:0] r_mem [0:239];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/scanline_fetch.sv
// scanline_fetch: double-buffered scanline prefetcher for bitmap modes 3 and 4,
// filling the back bank from VRAM/palette while the display reads the front bank.
module scanline_fetch
  import scanline_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dispcnt,
  input  logic        line_req,
  input  logic [7:0]  line_num,
  output logic        vram_rd,
  output logic [15:0] vram_addr,
  input  logic [15:0] vram_data,
  output logic        pal_rd,
  output logic [7:0]  pal_idx,
  input  logic [15:0] pal_data,
  input  logic [7:0]  px_col,
  output logic [14:0] px_data,
  output logic        busy,
  output logic        line_done,
  output logic        overrun
);
  state_t r_state, w_next;
  logic        r_front, r_page, r_vvalid, r_hi_valid, r_wr_en, r_px_zero, r_px_front, r_overrun;
  logic [1:0]  r_blank;
  logic [7:0]  r_line, r_cnt, r_pcol, r_wr_col, r_hi;
  logic        w_blank_req, w_rd3, w_rd4, w_unused;
  logic [14:0] w_wdata, w_rdata0, w_rdata1;
  logic [15:0] w_addr3, w_addr4;

  assign w_unused = ^{dispcnt[15:5], dispcnt[3], pal_data[15]};
  assign w_blank_req = line_num >= SCREEN_H || (dispcnt[2:0] != MODE3 && dispcnt[2:0] != MODE4);
  assign busy = r_state == FETCH3 || r_state == FETCH4;
  assign line_done = r_state == FINISH;
  assign overrun = r_overrun;
  assign w_rd3 = r_state == FETCH3 && r_cnt < SCREEN_W;
  assign w_rd4 = r_state == FETCH4 && r_cnt < SCREEN_W && !r_cnt[0];
  assign w_addr3 = {8'd0, r_line} * 16'd240 + {8'd0, r_cnt};
  assign w_addr4 = {8'd0, r_line} * 16'd120 + {9'd0, r_cnt[7:1]} + (r_page ? MODE4_PAGE1_BASE : 16'd0);
  assign vram_rd = w_rd3 | w_rd4;
  assign vram_addr = w_rd3 ? w_addr3 : w_rd4 ? w_addr4 : 16'd0;
  // Low byte goes out the cycle the word returns; high byte is replayed from r_hi next cycle.
  assign pal_rd = r_state == FETCH4 && (r_vvalid || r_hi_valid);
  assign pal_idx = !pal_rd ? 8'd0 : r_vvalid ? vram_data[7:0] : r_hi;
  assign w_wdata = r_state == FETCH3 ? vram_data[14:0] : pal_data[14:0];
  assign px_data = r_px_zero ? 15'd0 : r_px_front ? w_rdata1 : w_rdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end

  // One drain cycle after the last read lets the final write land before FINISH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH3:  w_next = r_cnt == SCREEN_W ? FINISH : FETCH3;
      FETCH4:  w_next = r_cnt == SCREEN_W + 8'd1 ? FINISH : FETCH4;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (line_req) w_next = w_blank_req ? FINISH : dispcnt[2:0] == MODE3 ? FETCH3 : FETCH4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front <= 1'b0;
      r_blank <= 2'b11;
      r_line <= '0;
      r_page <= 1'b0;
      r_overrun <= 1'b0;
      r_cnt <= '0;
      r_pcol <= '0;
      r_vvalid <= 1'b0;
      r_hi_valid <= 1'b0;
      r_hi <= '0;
      r_wr_en <= 1'b0;
      r_wr_col <= '0;
      r_px_zero <= 1'b1;
      r_px_front <= 1'b0;
    end else begin
      r_px_zero <= r_blank[r_front] || px_col >= SCREEN_W;
      r_px_front <= r_front;
      if (line_req) begin
        r_front <= ~r_front;
        r_blank[r_front] <= w_blank_req;
        r_line <= line_num;
        r_page <= dispcnt[4];
        r_overrun <= r_overrun | busy;
        r_cnt <= '0;
        r_pcol <= '0;
        r_vvalid <= 1'b0;
        r_hi_valid <= 1'b0;
        r_wr_en <= 1'b0;
      end else begin
        r_cnt <= busy ? r_cnt + 8'd1 : 8'd0;
        r_vvalid <= w_rd4;
        r_hi_valid <= r_vvalid;
        if (r_vvalid) r_hi <= vram_data[15:8];
        r_pcol <= r_pcol + {7'd0, pal_rd};
        r_wr_en <= w_rd3 | pal_rd;
        r_wr_col <= w_rd3 ? r_cnt : r_pcol;
      end
    end
  end

  line_ram u_bank0 (
    .clk(clk), .i_we(r_wr_en && r_front), .i_waddr(r_wr_col), .i_wdata(w_wdata),
    .i_raddr(px_col), .o_rdata(w_rdata0)
  );
  line_ram u_bank1 (
    .clk(clk), .i_we(r_wr_en && !r_front), .i_waddr(r_wr_col), .i_wdata(w_wdata),
    .i_raddr(px_col), .o_rdata(w_rdata1)
  );
endmodule

// File: tb/tb_scanline_fetch.sv
// tb_scanline_fetch: scoreboard bench with VRAM/palette models for scanline_fetch.
module tb_scanline_fetch;
  logic        clk = 1'b0;
  logic        rst, line_req, vram_rd, pal_rd, busy, line_done, overrun;
  logic [15:0] dispcnt, vram_addr, vram_data, pal_data;
  logic [7:0]  line_num, pal_idx, px_col;
  logic [14:0] px_data;
  int passed = 0, total = 0;
  logic [15:0] vram [0:65535];
  logic [15:0] pal [0:255];
  logic [15:0] addr_q[$];
  logic [14:0] exp_q[$];

  scanline_fetch dut (
    .clk(clk), .rst(rst), .dispcnt(dispcnt), .line_req(line_req), .line_num(line_num),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .pal_rd(pal_rd), .pal_idx(pal_idx), .pal_data(pal_data),
    .px_col(px_col), .px_data(px_data), .busy(busy), .line_done(line_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_rd) vram_data <= vram[vram_addr];
    if (pal_rd) pal_data <= pal[pal_idx];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [2:0] mode, input logic page, input logic [7:0] ln);
    dispcnt = {11'h155, page, 1'b1, mode};
    line_num = ln;
    line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; line_req = 1'b0; dispcnt = '0; line_num = '0; px_col = 8'd5;
    step(); step();
    total++; if (px_data !== 15'd0) $display("FAIL reset_px: got %0h expected 0", px_data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", overrun); else passed++;
    total++; if ({vram_rd, pal_rd, line_done} !== 3'b000) $display("FAIL reset_strobes: got %b expected 000", {vram_rd, pal_rd, line_done}); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_mode3();
    int nrd = 0, nbusy = 0, ndone = 0, done_at = -1;
    logic [15:0] e;
    for (int a = 480; a <= 719; a++) addr_q.push_back(16'(a));
    start_line(3'd3, 1'b0, 8'd2);
    for (int t = 1; t <= 260; t++) begin
      if (vram_rd) begin
        nrd++;
        e = addr_q.size() > 0 ? addr_q.pop_front() : 16'hFFFF;
        total++; if (vram_addr !== e) $display("FAIL m3_addr t=%0d: got %0d expected %0d", t, vram_addr, e); else passed++;
      end
      if (busy) nbusy++;
      if (line_done) begin ndone++; done_at = t; end
      step();
    end
    total++; if (nrd !== 240) $display("FAIL m3_reads: got %0d expected 240", nrd); else passed++;
    total++; if (nbusy !== 241) $display("FAIL m3_busy_cycles: got %0d expected 241", nbusy); else passed++;
    total++; if (ndone !== 1 || done_at !== 242) $display("FAIL m3_done: got %0d at T+%0d expected 1 at T+242", ndone, done_at); else passed++;
    start_line(3'd0, 1'b0, 8'd200);
    foreach (exp_q[i]) exp_q.delete(i);
    for (int k = 0; k < 6; k++) begin
      int c;
      logic [14:0] ex, got;
      c = k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 100 : k == 3 ? 239 : k == 4 ? 240 : 255;
      px_col = 8'(c);
      exp_q.push_back(c < 240 ? 15'(480 + c) : 15'd0);
      step();
      got = px_data; ex = exp_q.pop_front();
      total++; if (got !== ex) $display("FAIL m3_px col=%0d: got %0h expected %0h", c, got, ex); else passed++;
    end
  endtask

  task automatic test_mode4();
    int nrd = 0, npal = 0, pfirst = -1, plast = -1, odd_bad = 0, done_at = -1;
    logic [15:0] e;
    vram[16'hA000] = 16'h0201;
    pal[1] = 16'h001F;
    pal[2] = 16'h7C00;
    for (int w = 0; w < 120; w++) addr_q.push_back(16'hA000 + 16'(w));
    start_line(3'd4, 1'b1, 8'd0);
    for (int t = 1; t <= 260; t++) begin
      if (vram_rd) begin
        nrd++;
        if (t % 2 == 0) odd_bad++;
        e = addr_q.size() > 0 ? addr_q.pop_front() : 16'hFFFF;
        total++; if (vram_addr !== e) $display("FAIL m4_addr t=%0d: got %0h expected %0h", t, vram_addr, e); else passed++;
      end
      if (pal_rd) begin npal++; if (pfirst < 0) pfirst = t; plast = t; end
      if (line_done) done_at = t;
      step();
    end
    total++; if (nrd !== 120 || odd_bad !== 0) $display("FAIL m4_reads: got %0d (%0d even) expected 120 (0 even)", nrd, odd_bad); else passed++;
    total++; if (npal !== 240 || pfirst !== 2 || plast !== 241) $display("FAIL m4_pal: got %0d T+%0d..T+%0d expected 240 T+2..T+241", npal, pfirst, plast); else passed++;
    total++; if (done_at !== 243) $display("FAIL m4_done: got T+%0d expected T+243", done_at); else passed++;
    start_line(3'd0, 1'b0, 8'd161);
    for (int k = 0; k < 8; k++) begin
      int c;
      logic [15:0] wd;
      logic [14:0] ex, got;
      c = k == 0 ? 0 : k == 1 ? 1 : k == 2 ? 2 : k == 3 ? 3 : k == 4 ? 101 : k == 5 ? 239 : k == 6 ? 240 : 255;
      wd = vram[16'hA000 + 16'(c / 2)];
      px_col = 8'(c);
      exp_q.push_back(c >= 240 ? 15'd0 : (c % 2 == 0) ? pal[wd[7:0]][14:0] : pal[wd[15:8]][14:0]);
      step();
      got = px_data; ex = exp_q.pop_front();
      total++; if (got !== ex) $display("FAIL m4_px col=%0d: got %0h expected %0h", c, got, ex); else passed++;
    end
  endtask

  task automatic test_blank();
    int nmem, done_at;
    for (int r = 0; r < 2; r++) begin
      nmem = 0; done_at = -1;
      if (r == 0) start_line(3'd3, 1'b0, 8'd160);
      else start_line(3'd0, 1'b0, 8'd5);
      for (int t = 1; t <= 20; t++) begin
        if (vram_rd || pal_rd) nmem++;
        if (line_done && done_at < 0) done_at = t;
        step();
      end
      total++; if (nmem !== 0) $display("FAIL blank_reads r=%0d: got %0d expected 0", r, nmem); else passed++;
      total++; if (done_at !== 1) $display("FAIL blank_done r=%0d: got T+%0d expected T+1", r, done_at); else passed++;
      for (int k = 0; k < 3; k++) begin
        logic [14:0] got;
        px_col = k == 0 ? 8'd0 : k == 1 ? 8'd10 : 8'd239;
        exp_q.push_back(15'd0);
        step();
        got = px_data;
        total++; if (got !== exp_q.pop_front()) $display("FAIL blank_px r=%0d col=%0d: got %0h expected 0", r, px_col, got); else passed++;
      end
    end
  endtask

  task automatic test_overrun();
    int ndone = 0, done_at = -1;
    logic [14:0] got;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_pre: got %0b expected 0", overrun); else passed++;
    start_line(3'd3, 1'b0, 8'd5);
    for (int t = 1; t < 100; t++) begin
      if (line_done) ndone++;
      step();
    end
    start_line(3'd3, 1'b0, 8'd7);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %0b expected 1", overrun); else passed++;
    total++; if (vram_addr !== 16'd1680) $display("FAIL ovr_restart_addr: got %0d expected 1680", vram_addr); else passed++;
    px_col = 8'd98;
    exp_q.push_back(15'd1298);
    step();
    got = px_data;
    total++; if (got !== exp_q.pop_front()) $display("FAIL ovr_old_col98: got %0d expected 1298", got); else passed++;
    px_col = 8'd99;
    step();
    got = px_data;
    total++; if (got === 15'd1299) $display("FAIL ovr_old_col99: got %0d expected not 1299", got); else passed++;
    for (int t = 3; t <= 260; t++) begin
      if (line_done) begin ndone++; done_at = t; end
      step();
    end
    total++; if (ndone !== 1 || done_at !== 242) $display("FAIL ovr_done: got %0d at T'+%0d expected 1 at T'+242", ndone, done_at); else passed++;
    start_line(3'd0, 1'b0, 8'd170);
    for (int k = 0; k < 2; k++) begin
      px_col = k == 0 ? 8'd0 : 8'd239;
      exp_q.push_back(k == 0 ? 15'd1680 : 15'd1919);
      step();
      got = px_data;
      total++; if (got !== exp_q.pop_front()) $display("FAIL ovr_px col=%0d: got %0d expected %0d", px_col, got, k == 0 ? 1680 : 1919); else passed++;
    end
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b expected 1", overrun); else passed++;
  endtask

  task automatic test_reset_midfetch();
    int ndone = 0, nrd = 0;
    start_line(3'd3, 1'b0, 8'd1);
    for (int t = 1; t < 50; t++) step();
    rst = 1'b1;
    #1;
    total++; if ({busy, vram_rd, overrun} !== 3'b000) $display("FAIL rst_mid: got %b expected 000", {busy, vram_rd, overrun}); else passed++;
    step();
    rst = 1'b0;
    for (int t = 0; t < 260; t++) begin
      if (line_done) ndone++;
      if (vram_rd) nrd++;
      step();
    end
    total++; if (ndone !== 0 || nrd !== 0) $display("FAIL rst_mid_quiet: got %0d done %0d reads expected 0 0", ndone, nrd); else passed++;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) vram[a] = 16'(a) & 16'h7FFF;
    for (int i = 0; i < 256; i++) pal[i] = {1'b1, 15'(i * 37 + 5)};
    test_reset();
    test_mode3();
    test_mode4();
    test_blank();
    test_overrun();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
